// File: rtl/seq_verify_param.sv
// Player-sequence verifier: latches a target sequence, opens input after display, checks presses.
// Optional idle-press timeout enabled by defining SEQ_VERIFY_TIMEOUT_EN.
module seq_verify_param #(
   parameter int unsigned SYM_W       = 4,
   parameter int unsigned MAX_LEN     = 8,
   parameter int unsigned LVL_W       = 3,
   parameter int unsigned TIMEOUT_CYC = 50000000,
   localparam int unsigned IDX_W      = $clog2(MAX_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     newSequence,
   input  logic [MAX_LEN*SYM_W-1:0] Sequence,
   input  logic [LVL_W-1:0]         LVL,
   input  logic                     display_done,
   input  logic                     b_player,
   input  logic [SYM_W-1:0]         player_num,
   output logic                     correct,
   output logic                     incorrect,
   output logic                     timeout,
   output logic                     busy,
   output logic [IDX_W-1:0]         step
);

   // Wide enough that LVL+1 never wraps, whichever of LVL_W / IDX_W is larger.
   localparam int unsigned LEN_W = ((LVL_W > IDX_W) ? LVL_W : IDX_W) + 1;

   typedef enum logic [2:0] {StIdle, StLoaded, StInput, StPass, StFail} state_e;

   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("seq_verify_param: TIMEOUT_CYC must be at least 1");
   end

   state_e                   state_q, state_d;
   logic [MAX_LEN*SYM_W-1:0] seq_q, seq_d;
   logic [IDX_W-1:0]         len_q, len_d;
   logic [IDX_W-1:0]         step_q, step_d;
   logic                     correct_q, correct_d;
   logic                     incorrect_q, incorrect_d;
   logic                     timeout_q, timeout_d;
   logic                     busy_q, busy_d;

   logic [LEN_W-1:0] lvl_plus1;
   logic [IDX_W-1:0] new_len;
   logic [SYM_W-1:0] exp_sym;
   logic             last_sym;

`ifdef SEQ_VERIFY_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign lvl_plus1 = LEN_W'(LVL) + LEN_W'(1);
   assign new_len   = (lvl_plus1 > LEN_W'(MAX_LEN)) ? IDX_W'(MAX_LEN) : lvl_plus1[IDX_W-1:0];
   assign last_sym  = (step_q == len_q - IDX_W'(1));

   always_comb begin
      exp_sym = '0;
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
         if (step_q == IDX_W'(k)) exp_sym = seq_q[k*SYM_W +: SYM_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      len_d       = len_q;
      step_d      = step_q;
      correct_d   = correct_q;
      incorrect_d = incorrect_q;
      timeout_d   = timeout_q;
      busy_d      = busy_q;
`ifdef SEQ_VERIFY_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      if (newSequence) begin
         state_d     = StLoaded;
         seq_d       = Sequence;
         len_d       = new_len;
         step_d      = '0;
         correct_d   = 1'b0;
         incorrect_d = 1'b0;
         timeout_d   = 1'b0;
         busy_d      = 1'b0;
      end else begin
         unique case (state_q)
            StLoaded: begin
               if (display_done) begin
                  state_d = StInput;
                  busy_d  = 1'b1;
`ifdef SEQ_VERIFY_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
            StInput: begin
               if (b_player) begin
`ifdef SEQ_VERIFY_TIMEOUT_EN
                  cnt_d = '0;
`endif
                  if (player_num == exp_sym) begin
                     if (last_sym) begin
                        state_d   = StPass;
                        correct_d = 1'b1;
                        busy_d    = 1'b0;
                     end else begin
                        step_d = step_q + IDX_W'(1);
                     end
                  end else begin
                     state_d     = StFail;
                     incorrect_d = 1'b1;
                     busy_d      = 1'b0;
                  end
               end
`ifdef SEQ_VERIFY_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state_d     = StFail;
                  incorrect_d = 1'b1;
                  timeout_d   = 1'b1;
                  busy_d      = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         seq_q       <= '0;
         len_q       <= '0;
         step_q      <= '0;
         correct_q   <= 1'b0;
         incorrect_q <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SEQ_VERIFY_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         len_q       <= len_d;
         step_q      <= step_d;
         correct_q   <= correct_d;
         incorrect_q <= incorrect_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
`ifdef SEQ_VERIFY_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign correct   = correct_q;
   assign incorrect = incorrect_q;
   assign timeout   = timeout_q;
   assign busy      = busy_q;
   assign step      = step_q;

endmodule

// File: tb/tb_seq_verify_param.sv
// Bench for seq_verify_param: vector table, hand-written corner sequences, random run vs model.
module tb_seq_verify_param;

   localparam int TCYC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        newSequence;
   logic [31:0] Sequence;
   logic [3:0]  LVL;
   logic        display_done;
   logic        b_player;
   logic [3:0]  player_num;
   logic        correct, incorrect, timeout, busy;
   logic [3:0]  step;

   int n_cmp  = 0;
   int n_fail = 0;

   seq_verify_param #(
      .SYM_W      (4),
      .MAX_LEN    (8),
      .LVL_W      (4),
      .TIMEOUT_CYC(TCYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .newSequence (newSequence),
      .Sequence    (Sequence),
      .LVL         (LVL),
      .display_done(display_done),
      .b_player    (b_player),
      .player_num  (player_num),
      .correct     (correct),
      .incorrect   (incorrect),
      .timeout     (timeout),
      .busy        (busy),
      .step        (step)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ns;
      logic [31:0] sq;
      logic [3:0]  lvl;
      bit          dd;
      bit          bp;
      logic [3:0]  pn;
      bit          c;
      bit          i;
      bit          b;
      int          s;
   } vec_t;

   // Reference model: the round as a list of symbols, a cursor and a few flags.
   logic [3:0] m_sym[8];
   int         m_len, m_step, m_idle;
   bit         m_wait_disp, m_open, m_c, m_i, m_t;

   function automatic vec_t mkv(bit ns, logic [31:0] sq, logic [3:0] lvl, bit dd, bit bp,
                                logic [3:0] pn, bit c, bit i, bit b, int s);
      vec_t v;
      v.ns = ns; v.sq = sq; v.lvl = lvl; v.dd = dd; v.bp = bp; v.pn = pn;
      v.c = c; v.i = i; v.b = b; v.s = s;
      return v;
   endfunction

   task automatic drive(bit ns, logic [31:0] sq, logic [3:0] lvl, bit dd, bit bp, logic [3:0] pn);
      newSequence = ns; Sequence = sq; LVL = lvl; display_done = dd; b_player = bp; player_num = pn;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, bit c, bit i, bit t, bit b, int s);
      n_cmp++;
      if (correct !== c || incorrect !== i || timeout !== t || busy !== b || int'(step) != s) begin
         n_fail++;
         $display("FAIL %s: got c=%b i=%b t=%b busy=%b step=%0d, want c=%b i=%b t=%b busy=%b step=%0d",
                  name, correct, incorrect, timeout, busy, step, c, i, t, b, s);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) m_sym[k] = '0;
      m_len = 0; m_step = 0; m_idle = 0;
      m_wait_disp = 0; m_open = 0; m_c = 0; m_i = 0; m_t = 0;
   endtask

   task automatic model_cycle(bit ns, logic [31:0] sq, logic [3:0] lvl, bit dd, bit bp,
                              logic [3:0] pn);
      if (ns) begin
         for (int k = 0; k < 8; k++) m_sym[k] = sq[4*k +: 4];
         m_len = (int'(lvl) + 1 > 8) ? 8 : int'(lvl) + 1;
         m_step = 0; m_c = 0; m_i = 0; m_t = 0;
         m_wait_disp = 1; m_open = 0;
      end else if (m_wait_disp) begin
         if (dd) begin
            m_wait_disp = 0; m_open = 1; m_idle = 0;
         end
      end else if (m_open) begin
         if (bp) begin
            m_idle = 0;
            if (pn != m_sym[m_step]) begin
               m_i = 1; m_open = 0;
            end else if (m_step + 1 == m_len) begin
               m_c = 1; m_open = 0;
            end else begin
               m_step++;
            end
         end else begin
`ifdef SEQ_VERIFY_TIMEOUT_EN
            m_idle++;
            if (m_idle == TCYC) begin
               m_i = 1; m_t = 1; m_open = 0;
            end
`endif
         end
      end
   endtask

   vec_t vecs[28];

   initial begin
      rst = 1'b0;
      drive(0, 32'h0, 4'h0, 0, 0, 4'h0);
      tick();
      tick();
      check("reset", 0, 0, 0, 0, 0);
      rst = 1'b1;

      vecs[0]  = mkv(1, 32'h0000_4321, 4'd3, 0, 0, 4'h0, 0, 0, 0, 0);
      vecs[1]  = mkv(0, 32'h0, 4'd0, 1, 0, 4'h0, 0, 0, 1, 0);
      vecs[2]  = mkv(0, 32'h0, 4'd0, 0, 1, 4'h1, 0, 0, 1, 1);
      vecs[3]  = mkv(0, 32'h0, 4'd0, 0, 1, 4'h2, 0, 0, 1, 2);
      vecs[4]  = mkv(0, 32'h0, 4'd0, 0, 1, 4'h3, 0, 0, 1, 3);
      vecs[5]  = mkv(0, 32'h0, 4'd0, 0, 1, 4'h4, 1, 0, 0, 3);
      vecs[6]  = mkv(0, 32'h0, 4'd0, 0, 1, 4'h1, 1, 0, 0, 3);
      vecs[7]  = mkv(1, 32'h0000_4321, 4'd3, 0, 1, 4'h1, 0, 0, 0, 0);
      vecs[8]  = mkv(0, 32'h0, 4'd0, 0, 1, 4'h1, 0, 0, 0, 0);
      vecs[9]  = mkv(0, 32'h0, 4'd0, 1, 1, 4'h1, 0, 0, 1, 0);
      vecs[10] = mkv(0, 32'h0, 4'd0, 0, 1, 4'h1, 0, 0, 1, 1);
      vecs[11] = mkv(0, 32'h0, 4'd0, 0, 1, 4'h5, 0, 1, 0, 1);
      vecs[12] = mkv(0, 32'h0, 4'd0, 0, 1, 4'h2, 0, 1, 0, 1);
      vecs[13] = mkv(0, 32'h0, 4'd0, 1, 0, 4'h0, 0, 1, 0, 1);
      vecs[14] = mkv(1, 32'h8765_4321, 4'd15, 0, 0, 4'h0, 0, 0, 0, 0);
      vecs[15] = mkv(0, 32'h0, 4'd0, 1, 0, 4'h0, 0, 0, 1, 0);
      for (int k = 0; k < 7; k++)
         vecs[16+k] = mkv(0, 32'h0, 4'd0, 0, 1, 4'(k + 1), 0, 0, 1, k + 1);
      vecs[23] = mkv(0, 32'h0, 4'd0, 0, 1, 4'h8, 1, 0, 0, 7);
      vecs[24] = mkv(1, 32'h0000_0009, 4'd0, 0, 0, 4'h0, 0, 0, 0, 0);
      vecs[25] = mkv(0, 32'h0, 4'd0, 1, 0, 4'h0, 0, 0, 1, 0);
      vecs[26] = mkv(0, 32'h0, 4'd0, 0, 1, 4'h9, 1, 0, 0, 0);
      vecs[27] = mkv(0, 32'h0, 4'd0, 1, 1, 4'h3, 1, 0, 0, 0);

      for (int k = 0; k < 28; k++) begin
         drive(vecs[k].ns, vecs[k].sq, vecs[k].lvl, vecs[k].dd, vecs[k].bp, vecs[k].pn);
         tick();
         check($sformatf("vec%0d", k), vecs[k].c, vecs[k].i, 0, vecs[k].b, vecs[k].s);
      end

      // Reload mid-round, then reset mid-round.
      drive(1, 32'h0000_4321, 4'd3, 0, 0, 4'h0); tick();
      drive(0, 32'h0, 4'd0, 1, 0, 4'h0);         tick();
      drive(0, 32'h0, 4'd0, 0, 1, 4'h1);         tick();
      drive(0, 32'h0, 4'd0, 0, 1, 4'h2);         tick();
      check("mid_step2", 0, 0, 0, 1, 2);
      drive(1, 32'h0000_1234, 4'd1, 0, 1, 4'h3); tick();
      check("reload", 0, 0, 0, 0, 0);
      drive(0, 32'h0, 4'd0, 0, 1, 4'h4);         tick();
      check("reload_loaded", 0, 0, 0, 0, 0);
      drive(0, 32'h0, 4'd0, 1, 0, 4'h0);         tick();
      drive(0, 32'h0, 4'd0, 0, 1, 4'h4);         tick();
      check("reload_seq", 0, 0, 0, 1, 1);
      rst = 1'b0;
      drive(0, 32'h0, 4'd0, 0, 1, 4'h3);         tick();
      check("rst_mid", 0, 0, 0, 0, 0);
      rst = 1'b1;
      drive(0, 32'h0, 4'd0, 1, 1, 4'h0);         tick();
      drive(0, 32'h0, 4'd0, 0, 1, 4'h0);         tick();
      check("idle_ignores", 0, 0, 0, 0, 0);

      // Idle behaviour in INPUT.
      drive(1, 32'h0000_4321, 4'd3, 0, 0, 4'h0); tick();
      drive(0, 32'h0, 4'd0, 1, 0, 4'h0);         tick();
      drive(0, 32'h0, 4'd0, 0, 0, 4'h0);
`ifdef SEQ_VERIFY_TIMEOUT_EN
      for (int k = 0; k < TCYC - 1; k++) tick();
      check("to_edge", 0, 0, 0, 1, 0);
      drive(0, 32'h0, 4'd0, 0, 1, 4'h1);         tick();
      check("to_press_wins", 0, 0, 0, 1, 1);
      drive(0, 32'h0, 4'd0, 0, 0, 4'h0);
      for (int k = 0; k < TCYC - 1; k++) tick();
      check("to_before", 0, 0, 0, 1, 1);
      tick();
      check("to_fire", 0, 1, 1, 0, 1);
      drive(0, 32'h0, 4'd0, 0, 1, 4'h2);         tick();
      check("to_hold", 0, 1, 1, 0, 1);
`else
      for (int k = 0; k < 100; k++) tick();
      check("no_timeout", 0, 0, 0, 1, 0);
`endif

      // Random traffic against the model.
      rst = 1'b0;
      drive(0, 32'h0, 4'd0, 0, 0, 4'h0);
      tick();
      rst = 1'b1;
      model_reset();
      for (int n = 0; n < 4000; n++) begin
         bit          ns, dd, bp;
         logic [31:0] sq;
         logic [3:0]  lvl, pn;
         ns  = ($urandom_range(0, 24) == 0);
         sq  = $urandom;
         lvl = 4'($urandom_range(0, 15));
         dd  = ($urandom_range(0, 5) == 0);
         bp  = ($urandom_range(0, 2) == 0);
         pn  = ($urandom_range(0, 9) < 8) ? m_sym[m_step] : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b0;
            model_reset();
         end else begin
            rst = 1'b1;
            model_cycle(ns, sq, lvl, dd, bp, pn);
         end
         drive(ns, sq, lvl, dd, bp, pn);
         tick();
         check($sformatf("rand%0d", n), m_c, m_i, m_t, m_open, m_step);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
